// File: rtl/attn_job_if.sv
// attn_job_if: job descriptor valid/ready handshake and done pulse between scheduler and matmul engine
interface attn_job_if #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 16
);
  logic              job_valid;
  logic              job_ready;
  logic [2:0]        job_id;
  logic              job_a_sel;
  logic              job_b_sel;
  logic [ADDR_W-1:0] job_a_base;
  logic [ADDR_W-1:0] job_b_base;
  logic [ADDR_W-1:0] job_dst_base;
  logic              job_sp_en;
  logic [ADDR_W-1:0] job_sp_base;
  logic              job_sp_transpose;
  logic [DIM_W-1:0]  job_m;
  logic [DIM_W-1:0]  job_k;
  logic [DIM_W-1:0]  job_n;
  logic              job_done;
  modport master (
    output job_valid, job_id, job_a_sel, job_b_sel, job_a_base, job_b_base, job_dst_base,
           job_sp_en, job_sp_base, job_sp_transpose, job_m, job_k, job_n,
    input  job_ready, job_done
  );
  modport slave (
    input  job_valid, job_id, job_a_sel, job_b_sel, job_a_base, job_b_base, job_dst_base,
           job_sp_en, job_sp_base, job_sp_transpose, job_m, job_k, job_n,
    output job_ready, job_done
  );
endinterface

// File: rtl/attn_pass_scheduler.sv
// attn_pass_scheduler: reads SRAM headers, validates dims, lays out SRAM and issues the Q,K,V,S,Z matmul jobs
module attn_pass_scheduler #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dut_valid,
  output logic              dut_ready,
  output logic [ADDR_W-1:0] input_read_address,
  input  logic [DATA_W-1:0] input_read_data,
  output logic [ADDR_W-1:0] weight_read_address,
  input  logic [DATA_W-1:0] weight_read_data,
  attn_job_if.master        job,
  output logic              err
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR   = 3'd1;
  localparam logic [2:0] CALC  = 3'd2;
  localparam logic [2:0] ISSUE = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [ADDR_W-1:0] ONE = 1;
  typedef struct packed {
    logic [2:0]        id;
    logic              a_sel;
    logic              b_sel;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic [ADDR_W-1:0] dst;
    logic              sp_en;
    logic [ADDR_W-1:0] sp_base;
    logic              tr;
    logic [DIM_W-1:0]  m;
    logic [DIM_W-1:0]  k;
    logic [DIM_W-1:0]  n;
  } job_t;
  logic [2:0]         state_q, state_d;
  logic               err_q, err_d;
  logic [DIM_W-1:0]   m_q, m_d, d_q, d_d, d2_q, d2_d, n_q, n_d;
  job_t               job_q, job_d, nxt;
  logic [2*DIM_W-1:0] mn, mm, dn;
  logic [2*DIM_W+3:0] need_res, need_wt, lim;
  logic [ADDR_W-1:0]  mn_a, mm_a, dn_a, mn3;
  logic [2:0]         nid;
  logic               bad;
  always_comb begin
    mn = {{DIM_W{1'b0}}, m_q} * {{DIM_W{1'b0}}, n_q};
    mm = {{DIM_W{1'b0}}, m_q} * {{DIM_W{1'b0}}, m_q};
    dn = {{DIM_W{1'b0}}, d_q} * {{DIM_W{1'b0}}, n_q};
    need_res = {2'b0, mn, 2'b0} + {4'b0, mm};
    need_wt = {4'b0, dn} + {3'b0, dn, 1'b1};
    lim = '0;
    lim[ADDR_W] = 1'b1;
    bad = m_q == '0 || d_q == '0 || d2_q == '0 || n_q == '0 || d_q != d2_q ||
          need_res > lim || need_wt > lim;
    mn_a = mn[ADDR_W-1:0];
    mm_a = mm[ADDR_W-1:0];
    dn_a = dn[ADDR_W-1:0];
    mn3 = mn_a + mn_a + mn_a;
    nid = state_q == CALC ? 3'd0 : job_q.id + 3'd1;
    // descriptor for the job about to be issued; result SRAM holds Q,K,V,S,Z back to back
    nxt.id = nid;
    nxt.a_sel = nid >= 3'd3;
    nxt.b_sel = nid >= 3'd3;
    nxt.a_base = nid == 3'd4 ? mn3 : nid == 3'd3 ? '0 : ONE;
    nxt.b_base = nid == 3'd0 ? ONE : nid == 3'd1 ? ONE + dn_a : nid == 3'd2 ? ONE + dn_a + dn_a :
                 nid == 3'd3 ? '0 : mn_a;
    nxt.dst = nid == 3'd0 ? '0 : nid == 3'd1 ? mn_a : nid == 3'd2 ? mn_a + mn_a :
              nid == 3'd3 ? mn3 : mn3 + mm_a;
    nxt.sp_en = nid == 3'd1 || nid == 3'd2;
    nxt.sp_base = nid == 3'd2 ? mn_a : '0;
    nxt.tr = nid == 3'd1;
    nxt.m = m_q;
    nxt.k = nid == 3'd3 ? n_q : nid == 3'd4 ? m_q : d_q;
    nxt.n = nid == 3'd3 ? m_q : n_q;
  end
  always_comb begin
    state_d = state_q;
    err_d = err_q;
    job_d = job_q;
    m_d = m_q;
    d_d = d_q;
    d2_d = d2_q;
    n_d = n_q;
    case (state_q)
      IDLE: if (dut_valid) begin
        state_d = HDR;
        err_d = 1'b0;
      end
      HDR: begin
        m_d = input_read_data[DATA_W-1 -: DIM_W];
        d_d = input_read_data[DIM_W-1:0];
        d2_d = weight_read_data[DATA_W-1 -: DIM_W];
        n_d = weight_read_data[DIM_W-1:0];
        state_d = CALC;
      end
      CALC: if (bad) begin
        err_d = 1'b1;
        state_d = DONE;
      end else begin
        job_d = nxt;
        state_d = ISSUE;
      end
      ISSUE: if (job.job_ready) state_d = WAIT;
      WAIT: if (job.job_done) begin
        state_d = job_q.id < 3'd4 ? ISSUE : DONE;
        if (job_q.id < 3'd4) job_d = nxt;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      err_q <= 1'b0;
      job_q <= '0;
      m_q <= '0;
      d_q <= '0;
      d2_q <= '0;
      n_q <= '0;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
      job_q <= job_d;
      m_q <= m_d;
      d_q <= d_d;
      d2_q <= d2_d;
      n_q <= n_d;
    end
  end
  assign dut_ready = state_q == IDLE;
  assign err = err_q;
  assign input_read_address = '0;
  assign weight_read_address = '0;
  assign job.job_valid = state_q == ISSUE;
  assign job.job_id = job_q.id;
  assign job.job_a_sel = job_q.a_sel;
  assign job.job_b_sel = job_q.b_sel;
  assign job.job_a_base = job_q.a_base;
  assign job.job_b_base = job_q.b_base;
  assign job.job_dst_base = job_q.dst;
  assign job.job_sp_en = job_q.sp_en;
  assign job.job_sp_base = job_q.sp_base;
  assign job.job_sp_transpose = job_q.tr;
  assign job.job_m = job_q.m;
  assign job.job_k = job_q.k;
  assign job.job_n = job_q.n;
endmodule
